// File: rtl/kalman_pkg.sv
// Shared types and fixed-point helpers for the alpha-beta tracker.
package kalman_pkg;

  localparam int FRAC   = 6;
  localparam int ONE_FI = 1 << FRAC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREDICT,
    ST_CORRECT,
    ST_RESP
  } state_t;

  // Per-channel track bookkeeping; pos/vel live in separate ARCH_W-wide tables.
  typedef struct packed {
    logic       init;
    logic [3:0] coast;
  } chan_ctl_t;

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic [63:0] clamp_u(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (v < 64'sd0)  return '0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/kalman_ab_axis.sv
// One-axis alpha-beta predict/residual/correct, purely combinational.
// Products are ARCH_W+FRAC+1 bits wide; every result saturates to ARCH_W.
module kalman_ab_axis #(
  parameter int DISP_WIDTH = 11,
  parameter int FRAC       = 6,
  parameter int ARCH_W     = 24,
  parameter int ALPHA_FI   = 32,
  parameter int BETA_FI    = 16,
  parameter int T_STEP_FI  = 64
) (
  input  logic signed [ARCH_W-1:0]     pos,
  input  logic signed [ARCH_W-1:0]     vel,
  input  logic        [DISP_WIDTH-1:0] z,
  output logic signed [ARCH_W-1:0]     pred,
  output logic signed [ARCH_W-1:0]     pos_init,
  output logic signed [ARCH_W-1:0]     pos_corr,
  output logic signed [ARCH_W-1:0]     vel_corr
);
  import kalman_pkg::*;

  localparam int PW = ARCH_W + FRAC + 1;
  localparam logic signed [PW-1:0] T_P = PW'(T_STEP_FI);
  localparam logic signed [PW-1:0] A_P = PW'(ALPHA_FI);
  localparam logic signed [PW-1:0] B_P = PW'(BETA_FI);

  logic signed [PW-1:0]     vt;
  logic signed [PW-1:0]     ga;
  logic signed [PW-1:0]     gb;
  logic signed [63:0]       z_fi;
  logic signed [ARCH_W-1:0] r;

  always_comb begin
    vt       = (PW'(vel) * T_P) >>> FRAC;
    pred     = ARCH_W'(sat_s(64'(pos) + 64'(vt), ARCH_W));
    z_fi     = $signed({{(64 - DISP_WIDTH){1'b0}}, z}) <<< FRAC;
    r        = ARCH_W'(sat_s(z_fi - 64'(pred), ARCH_W));
    ga       = (PW'(r) * A_P) >>> FRAC;
    gb       = (PW'(r) * B_P) >>> FRAC;
    pos_init = ARCH_W'(sat_s(z_fi, ARCH_W));
    pos_corr = ARCH_W'(sat_s(64'(pred) + 64'(ga), ARCH_W));
    vel_corr = ARCH_W'(sat_s(64'(vel) + 64'(gb), ARCH_W));
  end

endmodule

// File: rtl/kalman_ab_tracker.sv
// N-channel alpha-beta tracker on one shared datapath; 3 cycles accept-to-m_valid, one request in flight, s_ready low until the result is taken.
// Coast/lost handling is built only when KALMAN_AB_COAST_EN is defined; otherwise s_meas_ok is ignored.
module kalman_ab_tracker #(
  parameter int DISP_WIDTH = 11,
  parameter int NUM_CH     = 4,
  parameter int FRAC       = kalman_pkg::FRAC,
  parameter int ARCH_W     = 24,
  parameter int ALPHA_FI   = 32,
  parameter int BETA_FI    = 16,
  parameter int T_STEP_FI  = kalman_pkg::ONE_FI,
  parameter int COAST_MAX  = 3,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CH_W-1:0]       s_ch,
  input  logic                  s_meas_ok,
  input  logic [DISP_WIDTH-1:0] s_z_x,
  input  logic [DISP_WIDTH-1:0] s_z_y,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CH_W-1:0]       m_ch,
  output logic [DISP_WIDTH-1:0] m_x,
  output logic [DISP_WIDTH-1:0] m_y,
  output logic                  m_lost
);
  import kalman_pkg::*;

  state_t state, state_nxt;

  logic [CH_W-1:0]       ch_q;
  logic [DISP_WIDTH-1:0] zx_q, zy_q;
  logic                  meas;

  logic signed [ARCH_W-1:0] pos_x_tab [NUM_CH];
  logic signed [ARCH_W-1:0] vel_x_tab [NUM_CH];
  logic signed [ARCH_W-1:0] pos_y_tab [NUM_CH];
  logic signed [ARCH_W-1:0] vel_y_tab [NUM_CH];
  chan_ctl_t                ctl_tab   [NUM_CH];

  logic signed [ARCH_W-1:0] wpos_x, wvel_x, wpos_y, wvel_y;
  chan_ctl_t                wctl;

  logic            in_range;
  logic [CH_W-1:0] ch_idx;

`ifdef KALMAN_AB_COAST_EN
  logic meas_q;
  assign meas = meas_q;
`else
  logic unused_meas;
  localparam int unused_coast_max = COAST_MAX;
  assign unused_meas = s_meas_ok;
  assign meas        = 1'b1;
`endif

  assign s_ready  = (state == ST_IDLE) & ~areset;
  assign in_range = (32'(ch_q) < NUM_CH);
  // Out-of-range requests alias entry 0 for the read but never write it.
  assign ch_idx   = in_range ? ch_q : '0;

  logic signed [ARCH_W-1:0] pred_x, init_x, corr_x, vcorr_x;
  logic signed [ARCH_W-1:0] pred_y, init_y, corr_y, vcorr_y;

  kalman_ab_axis #(
    .DISP_WIDTH(DISP_WIDTH), .FRAC(FRAC), .ARCH_W(ARCH_W),
    .ALPHA_FI(ALPHA_FI), .BETA_FI(BETA_FI), .T_STEP_FI(T_STEP_FI)
  ) u_axis_x (
    .pos(wpos_x), .vel(wvel_x), .z(zx_q),
    .pred(pred_x), .pos_init(init_x), .pos_corr(corr_x), .vel_corr(vcorr_x)
  );

  kalman_ab_axis #(
    .DISP_WIDTH(DISP_WIDTH), .FRAC(FRAC), .ARCH_W(ARCH_W),
    .ALPHA_FI(ALPHA_FI), .BETA_FI(BETA_FI), .T_STEP_FI(T_STEP_FI)
  ) u_axis_y (
    .pos(wpos_y), .vel(wvel_y), .z(zy_q),
    .pred(pred_y), .pos_init(init_y), .pos_corr(corr_y), .vel_corr(vcorr_y)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (s_valid) state_nxt = ST_PREDICT;
      ST_PREDICT: state_nxt = ST_CORRECT;
      ST_CORRECT: state_nxt = ST_RESP;
      ST_RESP:    if (m_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  logic                     wr_en, show, lost;
  logic signed [ARCH_W-1:0] wb_pos_x, wb_vel_x, wb_pos_y, wb_vel_y;
  chan_ctl_t                wb_ctl;
  logic [DISP_WIDTH-1:0]    out_x, out_y;

  always_comb begin
    wr_en    = 1'b0;
    show     = 1'b0;
    lost     = 1'b0;
    wb_pos_x = wpos_x;
    wb_vel_x = wvel_x;
    wb_pos_y = wpos_y;
    wb_vel_y = wvel_y;
    wb_ctl   = wctl;
    if (!in_range) begin
      lost = 1'b1;
    end else if (meas) begin
      wr_en        = 1'b1;
      show         = 1'b1;
      wb_ctl.init  = 1'b1;
      wb_ctl.coast = '0;
      if (!wctl.init) begin
        wb_pos_x = init_x;
        wb_vel_x = '0;
        wb_pos_y = init_y;
        wb_vel_y = '0;
      end else begin
        wb_pos_x = corr_x;
        wb_vel_x = vcorr_x;
        wb_pos_y = corr_y;
        wb_vel_y = vcorr_y;
      end
`ifdef KALMAN_AB_COAST_EN
    end else if (wctl.init) begin
      wr_en        = 1'b1;
      show         = 1'b1;
      wb_pos_x     = pred_x;
      wb_pos_y     = pred_y;
      wb_ctl.coast = wctl.coast + 4'd1;
      // The lost report still carries the last predicted position.
      if (wb_ctl.coast >= 4'(COAST_MAX)) begin
        lost         = 1'b1;
        wb_ctl.init  = 1'b0;
        wb_ctl.coast = '0;
      end
    end else begin
      lost = 1'b1;
`endif
    end
    out_x = show ? DISP_WIDTH'(clamp_u(64'(wb_pos_x >>> FRAC), DISP_WIDTH)) : '0;
    out_y = show ? DISP_WIDTH'(clamp_u(64'(wb_pos_y >>> FRAC), DISP_WIDTH)) : '0;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ch_q    <= '0;
      zx_q    <= '0;
      zy_q    <= '0;
`ifdef KALMAN_AB_COAST_EN
      meas_q  <= 1'b0;
`endif
      wpos_x  <= '0;
      wvel_x  <= '0;
      wpos_y  <= '0;
      wvel_y  <= '0;
      wctl    <= '0;
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_x     <= '0;
      m_y     <= '0;
      m_lost  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pos_x_tab[i] <= '0;
        vel_x_tab[i] <= '0;
        pos_y_tab[i] <= '0;
        vel_y_tab[i] <= '0;
        ctl_tab[i]   <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: if (s_valid) begin
          ch_q   <= s_ch;
          zx_q   <= s_z_x;
          zy_q   <= s_z_y;
`ifdef KALMAN_AB_COAST_EN
          meas_q <= s_meas_ok;
`endif
        end
        ST_PREDICT: begin
          wpos_x <= pos_x_tab[ch_idx];
          wvel_x <= vel_x_tab[ch_idx];
          wpos_y <= pos_y_tab[ch_idx];
          wvel_y <= vel_y_tab[ch_idx];
          wctl   <= ctl_tab[ch_idx];
        end
        ST_CORRECT: begin
          if (wr_en) begin
            pos_x_tab[ch_idx] <= wb_pos_x;
            vel_x_tab[ch_idx] <= wb_vel_x;
            pos_y_tab[ch_idx] <= wb_pos_y;
            vel_y_tab[ch_idx] <= wb_vel_y;
            ctl_tab[ch_idx]   <= wb_ctl;
          end
          m_valid <= 1'b1;
          m_ch    <= ch_q;
          m_x     <= out_x;
          m_y     <= out_y;
          m_lost  <= lost;
        end
        ST_RESP: if (m_ready) m_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_ab_tracker.sv
// Directed bench for kalman_ab_tracker with hand-computed expected values.
module tb_kalman_ab_tracker;
  localparam int DW  = 11;
  localparam int NCH = 5;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           areset;
  logic           s_valid, s_ready, s_meas_ok;
  logic [CHW-1:0] s_ch;
  logic [DW-1:0]  s_z_x, s_z_y;
  logic           m_valid, m_ready, m_lost;
  logic [CHW-1:0] m_ch;
  logic [DW-1:0]  m_x, m_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kalman_ab_tracker #(.NUM_CH(NCH)) dut (
    .clk(clk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_meas_ok(s_meas_ok),
    .s_z_x(s_z_x), .s_z_y(s_z_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch),
    .m_x(m_x), .m_y(m_y), .m_lost(m_lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request; checks latency and result, optionally stalls m_ready first.
  task automatic txn(input string tag, input int ch, input bit ok, input int zx, input int zy,
                     input int ex, input int ey, input bit el, input int stall);
    int lat;
    @(negedge clk);
    check({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    s_valid   = 1'b1;
    s_ch      = CHW'(ch);
    s_meas_ok = ok;
    s_z_x     = DW'(zx);
    s_z_y     = DW'(zy);
    @(posedge clk);
    #1 s_valid = 1'b0;
    lat = 0;
    while (m_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    check({tag, ".m_ch"},    32'(m_ch), 32'(ch));
    check({tag, ".m_x"},     32'(m_x), 32'(ex));
    check({tag, ".m_y"},     32'(m_y), 32'(ey));
    check({tag, ".m_lost"},  32'(m_lost), 32'(el));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, {8'd0, m_valid, s_ready, m_lost, m_x, m_y},
            {8'd0, 1'b1, 1'b0, el, DW'(ex), DW'(ey)});
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    if (stall > 0) begin
      check({tag, ".release_s_ready"}, 32'(s_ready), 32'd1);
      check({tag, ".release_m_valid"}, 32'(m_valid), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; s_valid = 1'b0; s_ch = '0; s_meas_ok = 1'b0;
    s_z_x = '0; s_z_y = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.m_valid", 32'(m_valid), 32'd0);
    check("rst.m_x",     32'(m_x),     32'd0);
    check("rst.m_y",     32'(m_y),     32'd0);
    check("rst.m_lost",  32'(m_lost),  32'd0);
    check("rst.m_ch",    32'(m_ch),    32'd0);
    check("rst.s_ready", 32'(s_ready), 32'd0);
    areset = 1'b0;
    @(negedge clk);
    check("rst.s_ready_after", 32'(s_ready), 32'd1);

    txn("ch0_first",  0, 1'b1, 100, 200, 100, 200, 1'b0, 0);
    txn("ch0_second", 0, 1'b1, 110, 200, 105, 200, 1'b0, 0);
    txn("ch1_first",  1, 1'b1, 500,  50, 500,  50, 1'b0, 10);
    txn("ch5_range",  5, 1'b1,  20,  30,   0,   0, 1'b1, 0);
    txn("ch0_third",  0, 1'b1, 110, 200, 108, 200, 1'b0, 0);

    // Channel 2 drifts below zero: position -60 (Q6) clamps to 0 on the display.
    txn("ch2_a", 2, 1'b1, 10, 2047, 10, 2047, 1'b0, 0);
    txn("ch2_b", 2, 1'b1,  0, 2047,  5, 2047, 1'b0, 0);
    txn("ch2_c", 2, 1'b1,  0, 2047,  1, 2047, 1'b0, 0);
    txn("ch2_d", 2, 1'b1,  0, 2047,  0, 2047, 1'b0, 0);

    pulse_reset();
    txn("re_ch0_first",  0, 1'b1, 100, 200, 100, 200, 1'b0, 0);
    txn("re_ch0_second", 0, 1'b1, 110, 200, 105, 200, 1'b0, 0);
`ifdef KALMAN_AB_COAST_EN
    txn("coast1", 0, 1'b0, 0, 0, 107, 200, 1'b0, 0);
    txn("coast2", 0, 1'b0, 0, 0, 110, 200, 1'b0, 0);
    txn("coast3", 0, 1'b0, 0, 0, 112, 200, 1'b1, 0);
    txn("reinit", 0, 1'b1, 300, 300, 300, 300, 1'b0, 0);
    txn("ch3_uninit_coast", 3, 1'b0, 40, 50, 0, 0, 1'b1, 0);
`else
    txn("nocoast_meas", 0, 1'b0, 110, 200, 108, 200, 1'b0, 0);
    txn("ch3_nocoast",  3, 1'b0,  40,  50,  40,  50, 1'b0, 0);
`endif

    // Reset lands while the request sits in CORRECT.
    @(negedge clk);
    s_valid = 1'b1; s_ch = '0; s_meas_ok = 1'b1; s_z_x = DW'(50); s_z_y = DW'(60);
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(posedge clk);
    #1 areset = 1'b1;
    #1;
    check("abort.m_valid", 32'(m_valid), 32'd0);
    check("abort.s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    areset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.no_result", 32'(m_valid), 32'd0);
    txn("post_abort_ch0", 0, 1'b1, 70, 80, 70, 80, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
